// File: rtl/pl_mips_pkg.sv
// pl_mips_pkg: shared types and constants for the pipelined MIPS memory arbiter.
package pl_mips_pkg;
    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} arb_state_t;
    localparam logic [31:0] ARB_ERR_RDATA = '0;
endpackage

// File: rtl/pl_mem_arbiter_if.sv
// pl_mem_arbiter_if: pipeline request/ack signals plus the shared memory port.
interface pl_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req, if_ack;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_rd, dm_wr, dm_ack;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              stall_if, stall_mem;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              bus_error;

    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, bus_error
    );
    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, bus_error
    );
endinterface

// File: rtl/pl_mem_arbiter.sv
// pl_mem_arbiter: shares one memory port between fetch and data access, with
// fetch starvation protection and a per-transaction timeout.
module pl_mem_arbiter import pl_mips_pkg::*; #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input logic           clk,
    input logic           rst_n,
    pl_mem_arbiter_if.slave bus
);
    localparam logic [3:0] SMAX  = 4'(STARVE_MAX);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR = DATA_W'(ARB_ERR_RDATA);

    arb_state_t        state, state_n;
    logic [3:0]        starve_cnt, starve_n;
    logic [7:0]        to_cnt, to_n;
    logic              mem_req, mem_req_n, mem_we, mem_we_n;
    logic [ADDR_W-1:0] mem_addr, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata, mem_wdata_n, if_rdata, if_rdata_n, dm_rdata, dm_rdata_n;
    logic              if_ack, if_ack_n, dm_ack, dm_ack_n, bus_error, bus_error_n;
    logic              dm_req, if_win, done, abort;

    assign dm_req = bus.dm_rd | bus.dm_wr;
    assign if_win = bus.if_req & (~dm_req | starve_cnt == SMAX);
    // an ack on the terminal-count cycle still completes normally
    assign done   = state != IDLE & bus.mem_ack;
    assign abort  = state != IDLE & ~bus.mem_ack & to_cnt == TLAST;

    always_comb begin
        state_n     = state;
        starve_n    = starve_cnt;
        to_n        = to_cnt;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;
        if_ack_n    = 1'b0;
        dm_ack_n    = 1'b0;
        bus_error_n = 1'b0;
        if (state == IDLE) begin
            to_n     = '0;
            starve_n = bus.if_req ? starve_cnt : '0;
            if (if_win) begin
                state_n    = IF_BUSY;
                mem_req_n  = 1'b1;
                mem_we_n   = 1'b0;
                mem_addr_n = bus.if_addr;
                starve_n   = '0;
            end else if (bus.dm_rd & bus.dm_wr) begin
                dm_ack_n    = 1'b1;
                bus_error_n = 1'b1;
                dm_rdata_n  = ERR;
            end else if (dm_req) begin
                state_n     = DM_BUSY;
                mem_req_n   = 1'b1;
                mem_we_n    = bus.dm_wr;
                mem_addr_n  = bus.dm_addr;
                mem_wdata_n = bus.dm_wdata;
                starve_n    = bus.if_req ? starve_cnt + 4'd1 : '0;
            end
        end else begin
            to_n = to_cnt + 8'd1;
            if (done | abort) begin
                state_n     = IDLE;
                mem_req_n   = 1'b0;
                if_ack_n    = state == IF_BUSY;
                dm_ack_n    = state == DM_BUSY;
                bus_error_n = abort;
                if_rdata_n  = state == IF_BUSY ? (abort ? ERR : bus.mem_rdata) : if_rdata;
                dm_rdata_n  = state == DM_BUSY && (abort || !mem_we) ? (abort ? ERR : bus.mem_rdata) : dm_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            to_cnt     <= to_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            if_rdata   <= if_rdata_n;
            dm_rdata   <= dm_rdata_n;
            if_ack     <= if_ack_n;
            dm_ack     <= dm_ack_n;
            bus_error  <= bus_error_n;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_rdata  = if_rdata;
    assign bus.dm_rdata  = dm_rdata;
    assign bus.if_ack    = if_ack;
    assign bus.dm_ack    = dm_ack;
    assign bus.bus_error = bus_error;
    assign bus.stall_if  = bus.if_req & ~if_ack;
    assign bus.stall_mem = dm_req & ~dm_ack;
endmodule

// File: doc/pl_mem_arbiter.md
# pl_mem_arbiter

Arbiter and sequencer for the single shared memory port of the pipelined MIPS core. Arbitrates between instruction fetch (IF stage) and data access (MEM stage, lw/sw from the control decode), drives a req/ack memory handshake, and returns per-requester acks and stall signals to the pipeline. Adds starvation protection for fetch and a transaction timeout that reports `bus_error`.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch waits; range 1..15.
- `TIMEOUT`, 16: cycles in a busy state without `mem_ack` before abort; range 2..255.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched word, valid with `if_ack`.
- `if_ack` out 1: one-cycle fetch completion pulse.
- `dm_rd` / `dm_wr` in 1: data read (lw) / write (sw) request, held until `dm_ack`.
- `dm_addr` in ADDR_W, `dm_wdata` in DATA_W: data address / store data.
- `dm_rdata` out DATA_W: load data, valid with `dm_ack`.
- `dm_ack` out 1: one-cycle data completion pulse.
- `stall_if` / `stall_mem` out 1: pipeline stalls for IF / MEM stage.
- `mem_req`, `mem_we` out 1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W: memory command, registered, held until `mem_ack`.
- `mem_rdata` in DATA_W, `mem_ack` in 1: memory response; `mem_ack` may arrive in the first cycle `mem_req` is high.
- `bus_error` out 1: one-cycle pulse on timeout or illegal data request.

## Operation
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE: dm request (`dm_rd|dm_wr`) wins over `if_req` unless `starve_cnt == STARVE_MAX` and `if_req`, in which case fetch wins. On grant: latch address/wdata/we into `mem_*`, set `mem_req`, go to the busy state.
- `starve_cnt`: +1 on each dm grant while `if_req` high (saturating at STARVE_MAX); cleared on any IF grant or when `if_req` is low in IDLE.
- `dm_rd && dm_wr` in IDLE: no memory access; pulse `dm_ack` and `bus_error` next cycle, `dm_rdata` = 0.
- Busy: `mem_req` held with stable command. On `mem_ack`: clear `mem_req`, register `mem_rdata` into owner's rdata (writes: rdata unchanged), pulse owner's ack next cycle, return to IDLE.
- Timeout: `to_cnt` (8 bit) clears on grant, +1 per busy cycle; reaching TIMEOUT without ack aborts: `mem_req` low, owner ack + `bus_error` pulsed next cycle, owner rdata = 0, IDLE.
- `mem_ack` in IDLE (late/stale) is ignored.
- Requester dropping its request mid-transaction (flush): transaction completes, ack still pulsed; pipeline ignores it.
- `stall_if = if_req & ~if_ack`; `stall_mem = (dm_rd|dm_wr) & ~dm_ack` (combinational).

## Timing
- Reset (async assert): state IDLE, all `mem_*`, acks, `bus_error`, rdata outputs, `starve_cnt`, `to_cnt` = 0.
- Request seen in IDLE at cycle 0 → `mem_req` high cycle 1 → `mem_ack` in cycle k ≥ 1 → owner ack cycle k+1. Zero-wait latency: 2 cycles.
- Ack cycle is spent in IDLE and can grant the next request: back-to-back transactions every 2 cycles at zero wait.
- Requester must sample the new request only after its ack; a held request in the ack cycle is treated as a new request (pipeline deasserts or advances address in that cycle).
- Simultaneous `mem_ack` and timeout terminal count: ack wins, no `bus_error`.
- Reset mid-transaction: `mem_req` drops asynchronously; no ack pulses.

## Structure
- Shared package `pl_mips_pkg`: `arb_state_t` enum (IDLE, IF_BUSY, DM_BUSY), `ARB_ERR_RDATA` constant (0).
- Single module; starvation and timeout counters inline. No sub-module.

## Test plan
- Fetch only, `if_addr`=0x100, memory zero-wait returns 0x2002_0005 → `mem_req` cycle 1, `if_ack` cycle 2, `if_rdata`=0x2002_0005.
- `if_req` and `dm_wr` (addr 0x40, data 0xCAFE) same cycle, 1 wait state → write served first (`mem_we`=1), `dm_ack` cycle 3, then fetch granted cycle 3.
- Continuous dm reads with `if_req` held, STARVE_MAX=4 → 4 dm grants, 5th grant to IF, counter cleared.
- Memory never acks, TIMEOUT=16 → `mem_req` low after 16 busy cycles, `bus_error` and `dm_ack` pulse, `dm_rdata`=0; late `mem_ack` ignored.
- `dm_rd`=`dm_wr`=1 → no `mem_req`, `bus_error`+`dm_ack` next cycle.
- `rst_n` low while DM_BUSY → all outputs 0 immediately, state IDLE, no ack after release.
